// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every handshake and RAM-side signal of the unified instruction/data
// RAM port arbiter. The arbiter connects through the slave modport. Whatever
// drives the requests and models the RAM (pipeline glue, testbench) uses the
// master modport.
//
// Signal summary (direction as seen by the arbiter / slave):
//   if_req     in   fetch request, held until if_ready or if_flush
//   if_addr    in   fetch address, stable while if_req is high
//   if_flush   in   cancel the current fetch (branch/jump redirect)
//   if_rdata   out  fetched instruction, valid while if_ready is high
//   if_ready   out  one-cycle fetch completion pulse
//   mem_req    in   data request, held until mem_ready
//   mem_we     in   1 = store, 0 = load
//   mem_addr   in   data address
//   mem_wdata  in   store data
//   mem_rdata  out  load data, valid while mem_ready is high
//   mem_ready  out  one-cycle data completion pulse (loads and stores)
//   stall_if   out  fetch-stage stall (combinational)
//   stall_mem  out  memory-stage stall (combinational)
//   ram_en     out  RAM access strobe, one cycle per transaction
//   ram_we     out  RAM write enable, qualified by ram_en
//   ram_addr   out  registered RAM address
//   ram_wdata  out  registered RAM write data
//   ram_rdata  in   RAM read data
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  // Memory-stage requester
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Pipeline stalls
  logic              stall_if;
  logic              stall_mem;

  // RAM side
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  ram_rdata,
    output if_rdata, if_ready,
    output mem_rdata, mem_ready,
    output stall_if, stall_mem,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output ram_rdata,
    input  if_rdata, if_ready,
    input  mem_rdata, mem_ready,
    input  stall_if, stall_mem,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified instruction/data RAM port between the fetch stage
// (read-only) and the memory stage (read/write). The arbiter handles one RAM
// access at a time. It waits a fixed MEM_LAT cycles for read data and returns
// the result with a one-cycle ready pulse to whichever requester owns the
// access. The memory stage has fixed priority because it holds the older
// instruction. A branch/jump redirect (if_flush) cancels an outstanding fetch.
// The RAM access itself always runs to completion, but its result is dropped.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous, active-high reset
//   bus   mem_port_arbiter_if.slave. It carries the fetch and data request
//         handshakes, the stall outputs and the RAM strobe/address/data.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  cycles from the ram_en cycle to valid ram_rdata (1..15)
//
// Transaction timeline (request granted in cycle 0):
//   cycle 0          IDLE, grant, latch owner/addr/we/wdata
//   cycle 1          ISSUE, ram_en high
//   cycles 2..1+LAT  WAIT, counter runs down, capture in the last one
//   cycle 2+LAT      ready pulse to the owner, back in IDLE (next grant possible)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  // The counter is loaded in ISSUE and reaches zero in the cycle in which
  // ram_rdata is valid. That cycle is MEM_LAT cycles after the ram_en cycle.
  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic              owner_q,     owner_d;
  logic              cancel_q,    cancel_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q,  if_ready_d;
  logic              mem_ready_q, mem_ready_d;

  // -------------------------------------------------------------------------
  // Request qualification
  // -------------------------------------------------------------------------
  // A requester that sees its ready pulse this cycle still has req high for
  // the request that just completed. That request must not be granted again.
  // A fetch being redirected this cycle is not worth starting.
  logic if_eligible;
  logic mem_eligible;
  logic flush_hit;

  assign if_eligible  = bus.if_req  & ~if_ready_q & ~bus.if_flush;
  assign mem_eligible = bus.mem_req & ~mem_ready_q;

  // A redirect only matters while the fetch owns the port.
  assign flush_hit    = (owner_q == OWN_IF) & bus.if_flush;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cancel_q    <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cancel_q    <= cancel_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cancel_d    = cancel_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // Ready outputs are single-cycle pulses. They fall unless a capture
    // happens this cycle.
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        if (mem_eligible) begin
          // The memory stage wins ties because it holds the older instruction.
          owner_d = OWN_MEM;
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_we;
          wdata_d = bus.mem_wdata;
          state_d = ST_ISSUE;
        end else if (if_eligible) begin
          // A fetch never writes. wdata_q keeps its old value because the
          // RAM ignores it while ram_we is low.
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          we_d    = 1'b0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d    = LAT_LOAD;
        cancel_d = cancel_q | flush_hit;
        state_d  = ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // ram_rdata is valid this cycle. A redirect in this same cycle still
          // cancels the fetch, so the flush input is checked here as well as
          // the flag.
          state_d  = ST_IDLE;
          cancel_d = 1'b0;
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = bus.ram_rdata;
            mem_ready_d = 1'b1;
          end else if (!(cancel_q | flush_hit)) begin
            if_rdata_d  = bus.ram_rdata;
            if_ready_d  = 1'b1;
          end
        end else begin
          cnt_d    = cnt_q - 4'd1;
          cancel_d = cancel_q | flush_hit;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  logic ram_en_c;
  logic ram_we_c;
  logic stall_if_c;
  logic stall_mem_c;

  always_comb begin
    ram_en_c    = (state_q == ST_ISSUE);
    ram_we_c    = (state_q == ST_ISSUE) & (owner_q == OWN_MEM) & we_q;
    // The stalls follow the requests directly. They drop in the ready cycle
    // with no register delay, so the pipeline advances on the pulse itself.
    stall_if_c  = bus.if_req  & ~if_ready_q & ~bus.if_flush;
    stall_mem_c = bus.mem_req & ~mem_ready_q;
  end

  assign bus.ram_en    = ram_en_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.stall_if  = stall_if_c;
  assign bus.stall_mem = stall_mem_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Main DUT (MEM_LAT=2). A transaction-level model tracks the grant time and
// owner of the single outstanding access. All outputs follow from that
// timestamp: ram_en at grant+1, capture at grant+1+LAT, ready one cycle later.
// A compare process checks every output against the model on every cycle.
// Directed timelines pin the model with literal expectations. Random traffic
// then exercises loads, stores, fetches, redirects and resets.
//
// A second DUT (MEM_LAT=1) runs back-to-back loads with literal checks only.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit lat1_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model and per-cycle compare
  // ------------------------------------------------------------------
  bit          m_valid = 1'b0;
  bit          m_busy = 1'b0, m_own_mem = 1'b0, m_we = 1'b0, m_cancel = 1'b0;
  int          m_gcyc = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_mem_rdata = '0;
  bit          m_if_rdy = 1'b0, m_mem_rdy = 1'b0;
  bit          prev_if_rdy = 1'b0, prev_mem_rdy = 1'b0, prev_flush = 1'b0;
  int          n_txn = 0;

  always @(negedge clk) begin
    bit exp_en, exp_we, exp_sif, exp_smem, nxt_if, nxt_mem;
    exp_en   = m_busy && (cyc == m_gcyc + 1);
    exp_we   = exp_en && m_own_mem && m_we;
    exp_sif  = bus.if_req && !m_if_rdy && !bus.if_flush;
    exp_smem = bus.mem_req && !m_mem_rdy;
    if (m_valid) begin
      check("ram_en",    32'(bus.ram_en),    32'(exp_en));
      check("ram_we",    32'(bus.ram_we),    32'(exp_we));
      check("ram_addr",  bus.ram_addr,       m_addr);
      if (exp_we) check("ram_wdata", bus.ram_wdata, m_wdata);
      check("if_ready",  32'(bus.if_ready),  32'(m_if_rdy));
      check("mem_ready", 32'(bus.mem_ready), 32'(m_mem_rdy));
      check("if_rdata",  bus.if_rdata,       m_if_rdata);
      check("mem_rdata", bus.mem_rdata,      m_mem_rdata);
      check("stall_if",  32'(bus.stall_if),  32'(exp_sif));
      check("stall_mem", 32'(bus.stall_mem), 32'(exp_smem));
    end
    prev_if_rdy  = m_if_rdy;
    prev_mem_rdy = m_mem_rdy;
    prev_flush   = bus.if_flush;
    nxt_if  = 1'b0;
    nxt_mem = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_busy = 1'b0; m_cancel = 1'b0; m_own_mem = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
    end else if (m_busy) begin
      if (!m_own_mem && bus.if_flush) m_cancel = 1'b1;
      if (cyc == m_gcyc + 1 + LAT) begin
        m_busy = 1'b0;
        n_txn++;
        if (m_own_mem) begin
          m_mem_rdata = bus.ram_rdata;
          nxt_mem = 1'b1;
          $display("txn %0d: MEM %s addr=0x%08h rdata=0x%08h", n_txn, m_we ? "store" : "load ", m_addr, bus.ram_rdata);
        end else if (!m_cancel) begin
          m_if_rdata = bus.ram_rdata;
          nxt_if = 1'b1;
          $display("txn %0d: IF  fetch addr=0x%08h rdata=0x%08h", n_txn, m_addr, bus.ram_rdata);
        end else begin
          $display("txn %0d: IF  fetch addr=0x%08h cancelled by redirect", n_txn, m_addr);
        end
        m_cancel = 1'b0;
      end
    end else begin
      if (bus.mem_req && !m_mem_rdy) begin
        m_busy = 1'b1; m_gcyc = cyc; m_own_mem = 1'b1;
        m_addr = bus.mem_addr; m_we = bus.mem_we; m_wdata = bus.mem_wdata;
      end else if (bus.if_req && !m_if_rdy && !bus.if_flush) begin
        m_busy = 1'b1; m_gcyc = cyc; m_own_mem = 1'b0;
        m_addr = bus.if_addr; m_we = 1'b0;
      end
    end
    m_if_rdy  = nxt_if;
    m_mem_rdy = nxt_mem;
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  bit          rd_fixed = 1'b1;
  logic [31:0] rd_val   = 32'h8C08_0000;

  task automatic next_cycle();
    @(posedge clk);
    #1;
    bus.ram_rdata = rd_fixed ? rd_val : 32'($urandom());
  endtask

  task automatic idle_gap(input int n);
    bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.if_flush = 1'b0; bus.mem_we = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic new_mem();
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'($urandom_range(0, 1));
    bus.mem_addr  = 32'($urandom()) & 32'hFFFF_FFFC;
    bus.mem_wdata = 32'($urandom());
  endtask

  task automatic new_if();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'($urandom()) & 32'hFFFF_FFFC;
  endtask

  // ------------------------------------------------------------------
  // Main DUT stimulus
  // ------------------------------------------------------------------
  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.ram_rdata = '0;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset ram_en",    32'(bus.ram_en),    32'd0);
    check("reset if_ready",  32'(bus.if_ready),  32'd0);
    check("reset ram_addr",  bus.ram_addr,       32'd0);
    check("reset mem_rdata", bus.mem_rdata,      32'd0);
    rst = 1'b0;
    idle_gap(2);

    // Single fetch from 0x40
    for (int t = 0; t <= 6; t++) begin
      bus.if_req = (t <= 4); bus.if_addr = 32'h40;
      @(negedge clk);
      check("t1 ram_en",   32'(bus.ram_en),   32'(t == 1));
      check("t1 if_ready", 32'(bus.if_ready), 32'(t == 4));
      check("t1 stall_if", 32'(bus.stall_if), 32'(t <= 3));
      if (t == 1) check("t1 ram_addr", bus.ram_addr, 32'h40);
      if (t == 4) check("t1 if_rdata", bus.if_rdata, 32'h8C08_0000);
      next_cycle();
    end
    idle_gap(3);

    // Simultaneous fetch and load: memory stage first
    for (int t = 0; t <= 9; t++) begin
      bus.mem_req = (t <= 4); bus.mem_we = 1'b0; bus.mem_addr = 32'h100;
      bus.if_req  = (t <= 8); bus.if_addr = 32'h44;
      @(negedge clk);
      check("t2 ram_en",    32'(bus.ram_en),    32'(t == 1 || t == 5));
      check("t2 mem_ready", 32'(bus.mem_ready), 32'(t == 4));
      check("t2 if_ready",  32'(bus.if_ready),  32'(t == 8));
      check("t2 stall_if",  32'(bus.stall_if),  32'(t <= 7));
      check("t2 stall_mem", 32'(bus.stall_mem), 32'(t <= 3));
      if (t == 1) check("t2 ram_addr mem", bus.ram_addr, 32'h100);
      if (t == 5) check("t2 ram_addr if",  bus.ram_addr, 32'h44);
      if (t == 4) check("t2 mem_rdata",    bus.mem_rdata, 32'h8C08_0000);
      next_cycle();
    end
    idle_gap(3);

    // Store
    for (int t = 0; t <= 5; t++) begin
      bus.mem_req = (t <= 4); bus.mem_we = 1'b1; bus.mem_addr = 32'h0C; bus.mem_wdata = 32'h3;
      @(negedge clk);
      check("t3 ram_en&we", 32'(bus.ram_en & bus.ram_we), 32'(t == 1));
      check("t3 mem_ready", 32'(bus.mem_ready), 32'(t == 4));
      if (t == 1) begin
        check("t3 ram_addr",  bus.ram_addr,  32'h0C);
        check("t3 ram_wdata", bus.ram_wdata, 32'h3);
      end
      next_cycle();
    end
    idle_gap(3);

    // Redirect cancels a fetch; the following fetch is served
    rd_val = 32'h1234_0080;
    for (int t = 0; t <= 10; t++) begin
      bus.if_req   = (t <= 2) || (t >= 5 && t <= 9);
      bus.if_addr  = (t < 5) ? 32'h60 : 32'h80;
      bus.if_flush = (t == 2);
      @(negedge clk);
      check("t4 if_ready", 32'(bus.if_ready), 32'(t == 9));
      check("t4 ram_en",   32'(bus.ram_en),   32'(t == 1 || t == 6));
      if (t == 4) check("t4 if_rdata kept", bus.if_rdata, 32'h8C08_0000);
      if (t == 6) check("t4 ram_addr",      bus.ram_addr, 32'h80);
      if (t == 9) check("t4 if_rdata",      bus.if_rdata, 32'h1234_0080);
      next_cycle();
    end
    idle_gap(3);

    // Reset during WAIT discards the fetch, which is then re-granted
    for (int t = 0; t <= 8; t++) begin
      bus.if_req = (t <= 7); bus.if_addr = 32'h20;
      rst = (t == 2);
      @(negedge clk);
      if (t == 3) begin
        check("t5 if_ready",  32'(bus.if_ready),  32'd0);
        check("t5 mem_ready", 32'(bus.mem_ready), 32'd0);
        check("t5 if_rdata",  bus.if_rdata,       32'd0);
        check("t5 mem_rdata", bus.mem_rdata,      32'd0);
        check("t5 ram_en",    32'(bus.ram_en),    32'd0);
        check("t5 ram_we",    32'(bus.ram_we),    32'd0);
        check("t5 ram_addr",  bus.ram_addr,       32'd0);
        check("t5 ram_wdata", bus.ram_wdata,      32'd0);
      end
      check("t5 ram_en seq", 32'(bus.ram_en),   32'(t == 1 || t == 4));
      check("t5 if_ready seq", 32'(bus.if_ready), 32'(t == 7));
      if (t == 7) check("t5 if_rdata seq", bus.if_rdata, 32'h1234_0080);
      next_cycle();
    end
    rst = 1'b0;
    idle_gap(3);

    // Random traffic
    rd_fixed = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (!bus.mem_req) begin
        if ($urandom_range(0, 3) == 0) new_mem();
      end else if (prev_mem_rdy) begin
        if ($urandom_range(0, 1) == 1) new_mem();
        else bus.mem_req = 1'b0;
      end
      if (!bus.if_req) begin
        if ($urandom_range(0, 2) == 0) new_if();
      end else if (prev_if_rdy || prev_flush) begin
        if ($urandom_range(0, 3) != 0) new_if();
        else bus.if_req = 1'b0;
      end
      bus.if_flush = bus.if_req && ($urandom_range(0, 9) == 0);
      next_cycle();
    end
    rst = 1'b0;
    idle_gap(12);

    if (!lat1_done) check("lat1 block finished", 32'(lat1_done), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ------------------------------------------------------------------
  // MEM_LAT=1: continuous loads, a new request right after each ready
  // ------------------------------------------------------------------
  initial begin
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.if_flush = 1'b0;
    bus1.mem_req = 1'b0; bus1.mem_we = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
    bus1.ram_rdata = '0;
    rst1 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      bus1.mem_req   = 1'b1;
      bus1.mem_we    = 1'b0;
      bus1.mem_addr  = 32'h200;
      bus1.ram_rdata = 32'hA000_0000 | 32'(t);
      @(negedge clk);
      check("lat1 ram_en",    32'(bus1.ram_en),    32'((t % 4) == 1));
      check("lat1 mem_ready", 32'(bus1.mem_ready), 32'((t % 4) == 3));
      if ((t % 4) == 3) check("lat1 mem_rdata", bus1.mem_rdata, 32'hA000_0000 | 32'(t - 1));
      @(posedge clk); #1;
    end
    bus1.mem_req = 1'b0;
    lat1_done = 1'b1;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the single unified instruction/data RAM port between the fetch stage (read-only) and the memory stage (read/write) of the 5-stage pipeline. Issues one RAM access at a time, waits a fixed RAM latency, and returns the data with a one-cycle ready pulse. Drives per-requester stall signals consumed by the pipeline register enables. Cancels outstanding fetches on branch/jump redirect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from ram_en cycle to ram_rdata valid; legal 1..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready or if_flush
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_flush  in  1  cancel the current fetch (branch/jump redirect)
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready high
- if_ready  out  1  one-cycle completion pulse, fetch
- mem_req  in  1  data request; held until mem_ready
- mem_we  in  1  1 = store, 0 = load; stable while mem_req high
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data; valid while mem_ready high
- mem_ready  out  1  one-cycle completion pulse, data (loads and stores)
- stall_if  out  1  combinational: if_req & ~if_ready & ~if_flush
- stall_mem  out  1  combinational: mem_req & ~mem_ready
- ram_en  out  1  RAM access strobe, exactly one cycle per transaction
- ram_we  out  1  RAM write enable, qualified by ram_en
- ram_addr  out  ADDR_W  RAM address, registered
- ram_wdata  out  DATA_W  RAM write data, registered
- ram_rdata  in  DATA_W  RAM read data

## Operation
- States: IDLE, ISSUE, WAIT. Owner register: IF or MEM. Cancel flag. Latency counter, 4 bits.
- IDLE: a requester is eligible when its req is high and its ready output is low this cycle (same-cycle re-request after ready ignored). IF is also ineligible while if_flush high.
- Priority fixed: MEM over IF (MEM holds the older instruction). Grant -> latch owner, addr, we, wdata into ram_* registers; next state ISSUE.
- ISSUE: ram_en=1 (ram_we=owner==MEM & we) for this cycle only; counter loaded with MEM_LAT-1; next WAIT.
- WAIT: decrement counter each cycle; when counter==0 (ram_rdata valid this cycle): capture ram_rdata into owner's rdata register, pulse owner's ready next cycle, go IDLE.
- Stores: same flow and same latency; mem_rdata holds captured value (don't-care for stores).
- Flush: if_flush high in any cycle while owner==IF in ISSUE/WAIT sets cancel; at completion if_ready stays 0 and if_rdata unchanged. RAM access is never aborted. Cancel cleared on return to IDLE.
- if_flush while owner==MEM or in IDLE: no effect on state beyond ineligibility of IF that cycle.
- Requester may drop req only after ready (IF also after flush); dropping mid-transaction is an illegal stimulus, result unspecified apart from no hang.
- rst: state IDLE, cancel 0, counter 0; all outputs 0 (if_ready, mem_ready, if_rdata, mem_rdata, ram_en, ram_we, ram_addr, ram_wdata). In-flight transaction discarded, no ready pulse.

## Timing
- Request high in cycle 0 (idle, granted) -> ram_en in cycle 1 -> ram_rdata sampled end of cycle 1+MEM_LAT -> ready in cycle 2+MEM_LAT. Latency req-to-ready = MEM_LAT+2.
- Next grant earliest in ready cycle for the other requester; same requester earliest cycle after ready. Throughput one access per MEM_LAT+2 cycles.
- Simultaneous if_req and mem_req in IDLE: MEM granted; IF waits, stall_if stays high throughout.
- stall_* have no register delay; drop in the ready cycle.

## Test plan
- MEM_LAT=2, if_req addr 0x40 at cycle 0, RAM returns 0x8C080000 -> ram_en cycle 1 only, if_ready cycle 4 with if_rdata=0x8C080000, stall_if high cycles 0-3.
- if_req and mem_req (load 0x100) both at cycle 0 -> MEM ram_en cycle 1, mem_ready cycle 4; IF ram_en cycle 5, if_ready cycle 8.
- Store mem_we=1 addr 0x0C wdata 0x0000_0003 -> ram_en&ram_we one cycle with ram_addr 0x0C, ram_wdata 3; mem_ready 4 cycles after req.
- Fetch granted, if_flush pulse cycle 2 -> no if_ready; new if_req addr 0x80 cycle 5 -> served, if_ready cycle 9 with 0x80 data.
- rst asserted in WAIT (cycle 2) for one cycle -> cycle 3 all outputs 0, no ready; pending req re-granted, ram_en cycle 4.
- MEM_LAT=1 back-to-back loads (req re-raised after ready) -> ready every 3/4 cycles, no duplicate ram_en.
